// File: rtl/axis_line_fifo.sv
// First-word fall-through FIFO for Axis beats with sof/eol sideband, fill level and complete-line count.
// Optional protocol checker (proto_err output) enabled by defining AXIS_LINE_FIFO_PROTOCOL_CHECK_EN.
module axis_line_fifo #(
  parameter  int DataWidth = 8,
  parameter  int Depth     = 16,
  localparam int AddrWidth = $clog2(Depth)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [DataWidth-1:0] s_data,
  input  logic                 s_valid,
  input  logic                 s_sof,
  input  logic                 s_eol,
  output logic                 s_ready,
  output logic [DataWidth-1:0] m_data,
  output logic                 m_valid,
  output logic                 m_sof,
  output logic                 m_eol,
  input  logic                 m_ready,
  output logic [AddrWidth:0]   level,
  output logic [AddrWidth:0]   lines,
  output logic                 line_avail
`ifdef AXIS_LINE_FIFO_PROTOCOL_CHECK_EN
  ,output logic                proto_err
`endif
);

  localparam logic [AddrWidth:0] One  = (AddrWidth+1)'(1);
  localparam logic [AddrWidth:0] Full = (AddrWidth+1)'(Depth);

  logic [DataWidth+1:0] mem [Depth];

  logic [AddrWidth:0] wr_ptr_reg, wr_ptr_next;
  logic [AddrWidth:0] rd_ptr_reg, rd_ptr_next;
  logic [AddrWidth:0] level_reg, level_next;
  logic [AddrWidth:0] lines_reg, lines_next;
  logic               s_ready_reg, s_ready_next;
  logic               line_avail_reg, line_avail_next;
  logic [DataWidth+1:0] head;
  logic               push, pop, push_eol, pop_eol;

  assign head       = mem[rd_ptr_reg[AddrWidth-1:0]];
  assign m_valid    = (level_reg != '0);
  assign m_data     = head[DataWidth-1:0];
  assign m_eol      = head[DataWidth];
  assign m_sof      = head[DataWidth+1];
  assign s_ready    = s_ready_reg;
  assign level      = level_reg;
  assign lines      = lines_reg;
  assign line_avail = line_avail_reg;

  assign push     = s_valid & s_ready_reg;
  assign pop      = m_valid & m_ready;
  assign push_eol = push & s_eol;
  assign pop_eol  = pop & m_eol;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    lines_next  = lines_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = '0;
      lines_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + One;
      if (pop)  rd_ptr_next = rd_ptr_reg + One;
      if (push && !pop)      level_next = level_reg + One;
      else if (pop && !push) level_next = level_reg - One;
      if (push_eol && !pop_eol)      lines_next = lines_reg + One;
      else if (pop_eol && !push_eol) lines_next = lines_reg - One;
    end
    // Ready is registered from the next level, so a pop while full frees the slot one cycle later.
    s_ready_next    = (level_next != Full);
    line_avail_next = (lines_next != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      lines_reg      <= '0;
      s_ready_reg    <= 1'b0;
      line_avail_reg <= 1'b0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      level_reg      <= level_next;
      lines_reg      <= lines_next;
      s_ready_reg    <= s_ready_next;
      line_avail_reg <= line_avail_next;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers and level.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr_reg[AddrWidth-1:0]] <= {s_sof, s_eol, s_data};
  end

`ifdef AXIS_LINE_FIFO_PROTOCOL_CHECK_EN
  logic last_eol_reg, last_eol_next;
  logic pend_reg, pend_next;
  logic proto_err_reg, proto_err_next;

  always_comb begin
    last_eol_next  = last_eol_reg;
    pend_next      = 1'b0;
    proto_err_next = proto_err_reg;
    if (flush) begin
      last_eol_next  = 1'b1;
      proto_err_next = 1'b0;
    end else begin
      // pend_reg marks a beat offered but not accepted last cycle; dropping valid then is an error.
      if ((push && s_sof && !last_eol_reg) || (pend_reg && !s_valid)) proto_err_next = 1'b1;
      if (push) last_eol_next = s_eol;
      pend_next = s_valid & ~push;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_eol_reg  <= 1'b1;
      pend_reg      <= 1'b0;
      proto_err_reg <= 1'b0;
    end else begin
      last_eol_reg  <= last_eol_next;
      pend_reg      <= pend_next;
      proto_err_reg <= proto_err_next;
    end
  end

  assign proto_err = proto_err_reg;
`endif

endmodule
